// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage LA32R pipeline, between decode and memory.
//
// Latches a decoded instruction from decode through a valid/allow-in handshake,
// computes the 12-operation ALU result, issues the data-SRAM request for
// ld.w/st.w in the cycle the instruction hands off to memory, publishes its
// destination for decode-side forwarding, and raises a load-use stall.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ds_to_es_valid             decode offers a valid instruction
//   ds_pc                      PC of the offered instruction
//   ds_alu_src1/ds_alu_src2    forwarded ALU operands
//   ds_alu_op                  one-hot ALU operation select
//   ds_mem_re / ds_mem_we      load flag / store byte enables
//   ds_st_data                 store data
//   ds_rf_we / ds_rf_waddr     register write enable / destination
//   ds_rf_raddr1/ds_rf_raddr2  sources of the instruction now in decode
//   ms_allow_in                memory stage can accept
//   es_allow_in                execute can accept
//   es_to_ms_valid             valid instruction leaving execute
//   es_pc, es_alu_result       latched PC and ALU result
//   es_res_from_mem            result comes from load data
//   es_rf_we/waddr/wdata       forwarding info (we gated by valid)
//   es_load_use_stall          decode must hold
//   data_sram_*                data SRAM request
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter logic [31:0] PC_RESET = 32'h1bfffffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    input  logic [31:0] ds_pc,
    input  logic [31:0] ds_alu_src1,
    input  logic [31:0] ds_alu_src2,
    input  logic [11:0] ds_alu_op,
    input  logic        ds_mem_re,
    input  logic [3:0]  ds_mem_we,
    input  logic [31:0] ds_st_data,
    input  logic [3:0]  ds_rf_we,
    input  logic [4:0]  ds_rf_waddr,
    input  logic [4:0]  ds_rf_raddr1,
    input  logic [4:0]  ds_rf_raddr2,
    input  logic        ms_allow_in,
    output logic        es_allow_in,
    output logic        es_to_ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_alu_result,
    output logic        es_res_from_mem,
    output logic [3:0]  es_rf_we,
    output logic [4:0]  es_rf_waddr,
    output logic [31:0] es_rf_wdata,
    output logic        es_load_use_stall,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata
);

    // Stage registers
    logic        es_valid_r;
    logic [31:0] pc_r;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic [11:0] alu_op_r;
    logic        mem_re_r;
    logic [3:0]  mem_we_r;
    logic [31:0] st_data_r;
    logic [3:0]  rf_we_r;
    logic [4:0]  rf_waddr_r;

    // Handshake and ALU intermediates
    logic        es_ready_go_s;
    logic        es_allow_in_s;
    logic        capture_s;
    logic        handoff_s;
    logic [4:0]  shamt_s;
    logic [31:0] add_s;
    logic [31:0] sub_s;
    logic [31:0] slt_s;
    logic [31:0] sltu_s;
    logic [31:0] and_s;
    logic [31:0] nor_s;
    logic [31:0] or_s;
    logic [31:0] xor_s;
    logic [31:0] sll_s;
    logic [31:0] srl_s;
    logic [31:0] sra_s;
    logic [31:0] lui_s;
    logic [31:0] alu_result_s;
    logic        hazard_match_s;

    // Every operation completes in one cycle.
    assign es_ready_go_s = 1'b1;
    assign es_allow_in_s = !es_valid_r | (es_ready_go_s & ms_allow_in);
    assign capture_s     = ds_to_es_valid & es_allow_in_s;
    // The single cycle in which the instruction is accepted by memory; the
    // SRAM request is confined to it so a stall never duplicates a request.
    assign handoff_s     = es_valid_r & es_ready_go_s & ms_allow_in;

    // Stage valid bit: refilled from decode whenever the stage can accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_r <= 1'b0;
        end else if (es_allow_in_s) begin
            es_valid_r <= ds_to_es_valid;
        end
    end

    // Payload registers: load on an accepted transfer, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= PC_RESET;
            src1_r     <= 32'h0000_0000;
            src2_r     <= 32'h0000_0000;
            alu_op_r   <= 12'h000;
            mem_re_r   <= 1'b0;
            mem_we_r   <= 4'h0;
            st_data_r  <= 32'h0000_0000;
            rf_we_r    <= 4'h0;
            rf_waddr_r <= 5'd0;
        end else if (capture_s) begin
            pc_r       <= ds_pc;
            src1_r     <= ds_alu_src1;
            src2_r     <= ds_alu_src2;
            alu_op_r   <= ds_alu_op;
            mem_re_r   <= ds_mem_re;
            mem_we_r   <= ds_mem_we;
            st_data_r  <= ds_st_data;
            rf_we_r    <= ds_rf_we;
            rf_waddr_r <= ds_rf_waddr;
        end
    end

    assign shamt_s = src2_r[4:0];

    // Per-operation results, selected below by AND-OR with the one-hot op.
    always_comb begin
        add_s  = src1_r + src2_r;
        sub_s  = src1_r - src2_r;
        slt_s  = {31'd0, ($signed(src1_r) < $signed(src2_r))};
        sltu_s = {31'd0, (src1_r < src2_r)};
        and_s  = src1_r & src2_r;
        nor_s  = ~(src1_r | src2_r);
        or_s   = src1_r | src2_r;
        xor_s  = src1_r ^ src2_r;
        sll_s  = src1_r << shamt_s;
        srl_s  = src1_r >> shamt_s;
        sra_s  = $unsigned($signed(src1_r) >>> shamt_s);
        lui_s  = src2_r;
    end

    // AND-OR mux: alu_op == 0 yields 0; a non-one-hot op ORs its selections.
    always_comb begin
        alu_result_s = ({32{alu_op_r[0]}}  & add_s)
                     | ({32{alu_op_r[1]}}  & sub_s)
                     | ({32{alu_op_r[2]}}  & slt_s)
                     | ({32{alu_op_r[3]}}  & sltu_s)
                     | ({32{alu_op_r[4]}}  & and_s)
                     | ({32{alu_op_r[5]}}  & nor_s)
                     | ({32{alu_op_r[6]}}  & or_s)
                     | ({32{alu_op_r[7]}}  & xor_s)
                     | ({32{alu_op_r[8]}}  & sll_s)
                     | ({32{alu_op_r[9]}}  & srl_s)
                     | ({32{alu_op_r[10]}} & sra_s)
                     | ({32{alu_op_r[11]}} & lui_s);
    end

    // A load in execute cannot forward its data yet (wdata is the address),
    // so a dependent instruction in decode has to wait.
    assign hazard_match_s = (rf_waddr_r == ds_rf_raddr1) | (rf_waddr_r == ds_rf_raddr2);

    assign es_allow_in       = es_allow_in_s;
    assign es_to_ms_valid    = es_valid_r & es_ready_go_s;
    assign es_pc             = pc_r;
    assign es_alu_result     = alu_result_s;
    assign es_res_from_mem   = es_valid_r & mem_re_r;
    assign es_rf_we          = es_valid_r ? rf_we_r : 4'h0;
    assign es_rf_waddr       = rf_waddr_r;
    assign es_rf_wdata       = alu_result_s;
    assign es_load_use_stall = es_valid_r & mem_re_r & (rf_we_r != 4'h0)
                             & (rf_waddr_r != 5'd0) & hazard_match_s;
    assign data_sram_en      = handoff_s & (mem_re_r | (mem_we_r != 4'h0));
    assign data_sram_we      = handoff_s ? mem_we_r : 4'h0;
    assign data_sram_addr    = alu_result_s;
    assign data_sram_wdata   = st_data_r;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Self-checking bench for exe_stage. Expected hand-off values are pushed to a
// scoreboard queue when an instruction is captured and popped at the falling
// edge on which the DUT hands it to memory.
// -----------------------------------------------------------------------------
module tb_exe_stage;

    localparam logic [31:0] PC_RST = 32'h1bfffffc;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    logic        clk;
    logic        reset;
    logic        ds_to_es_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_alu_src1;
    logic [31:0] ds_alu_src2;
    logic [11:0] ds_alu_op;
    logic        ds_mem_re;
    logic [3:0]  ds_mem_we;
    logic [31:0] ds_st_data;
    logic [3:0]  ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic [4:0]  ds_rf_raddr1;
    logic [4:0]  ds_rf_raddr2;
    logic        ms_allow_in;
    logic        es_allow_in;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic        es_res_from_mem;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_rf_wdata;
    logic        es_load_use_stall;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] wdata;
        logic        en;
        logic [3:0]  we;
        logic [3:0]  rf_we;
        logic [4:0]  waddr;
        logic        rfm;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   req_count;
    logic model_valid;

    exe_stage #(.PC_RESET(PC_RST)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_to_es_valid    (ds_to_es_valid),
        .ds_pc             (ds_pc),
        .ds_alu_src1       (ds_alu_src1),
        .ds_alu_src2       (ds_alu_src2),
        .ds_alu_op         (ds_alu_op),
        .ds_mem_re         (ds_mem_re),
        .ds_mem_we         (ds_mem_we),
        .ds_st_data        (ds_st_data),
        .ds_rf_we          (ds_rf_we),
        .ds_rf_waddr       (ds_rf_waddr),
        .ds_rf_raddr1      (ds_rf_raddr1),
        .ds_rf_raddr2      (ds_rf_raddr2),
        .ms_allow_in       (ms_allow_in),
        .es_allow_in       (es_allow_in),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_pc             (es_pc),
        .es_alu_result     (es_alu_result),
        .es_res_from_mem   (es_res_from_mem),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_rf_wdata       (es_rf_wdata),
        .es_load_use_stall (es_load_use_stall),
        .data_sram_en      (data_sram_en),
        .data_sram_we      (data_sram_we),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference occupancy of the stage, independent of the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_valid = 1'b0;
        end else if (!model_valid || ms_allow_in) begin
            model_valid = ds_to_es_valid;
        end
    end

    // Falling-edge monitor: handshake outputs, request gating, scoreboard pop.
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("valid", {31'd0, es_to_ms_valid}, {31'd0, model_valid});
            check_eq("allow_in", {31'd0, es_allow_in}, {31'd0, (!model_valid | ms_allow_in)});
            if (data_sram_en) req_count = req_count + 1;
            if (model_valid && !ms_allow_in) begin
                check_eq("bp_en", {31'd0, data_sram_en}, 32'd0);
                check_eq("bp_we", {28'd0, data_sram_we}, 32'd0);
            end
            if (model_valid && ms_allow_in) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("pc", es_pc, e.pc);
                    check_eq("alu_result", es_alu_result, e.res);
                    check_eq("rf_wdata", es_rf_wdata, e.res);
                    check_eq("sram_en", {31'd0, data_sram_en}, {31'd0, e.en});
                    check_eq("sram_we", {28'd0, data_sram_we}, {28'd0, e.we});
                    check_eq("sram_addr", data_sram_addr, e.res);
                    check_eq("sram_wdata", data_sram_wdata, e.wdata);
                    check_eq("rf_we", {28'd0, es_rf_we}, {28'd0, e.rf_we});
                    check_eq("rf_waddr", {27'd0, es_rf_waddr}, {27'd0, e.waddr});
                    check_eq("res_from_mem", {31'd0, es_res_from_mem}, {31'd0, e.rfm});
                end
            end
        end
    end

    // Offer one instruction; caller guarantees the stage can accept it.
    task automatic send(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [11:0] op, input logic re, input logic [3:0] we,
                        input logic [31:0] sd, input logic [3:0] rfwe, input logic [4:0] wa,
                        input logic [31:0] exp_res);
        exp_t e;
        ds_to_es_valid = 1'b1;
        ds_pc       = pc;
        ds_alu_src1 = s1;
        ds_alu_src2 = s2;
        ds_alu_op   = op;
        ds_mem_re   = re;
        ds_mem_we   = we;
        ds_st_data  = sd;
        ds_rf_we    = rfwe;
        ds_rf_waddr = wa;
        e.pc    = pc;
        e.res   = exp_res;
        e.wdata = sd;
        e.en    = re | (we != 4'h0);
        e.we    = we;
        e.rf_we = rfwe;
        e.waddr = wa;
        e.rfm   = re;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        ds_to_es_valid = 1'b0;
    endtask

    // Let a held instruction hand off, leaving the stage empty.
    task automatic drain();
        ms_allow_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [11:0] sw_op  [12];
    logic [31:0] sw_s2  [12];
    logic [31:0] sw_exp [12];

    initial begin
        checks = 0;
        errors = 0;
        req_count = 0;
        model_valid = 1'b0;
        reset = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_pc = 32'h0;
        ds_alu_src1 = 32'h0;
        ds_alu_src2 = 32'h0;
        ds_alu_op = 12'h0;
        ds_mem_re = 1'b0;
        ds_mem_we = 4'h0;
        ds_st_data = 32'h0;
        ds_rf_we = 4'h0;
        ds_rf_waddr = 5'd0;
        ds_rf_raddr1 = 5'd30;
        ds_rf_raddr2 = 5'd31;
        ms_allow_in = 1'b1;

        // Outputs under reset
        #2;
        check_eq("rst_valid", {31'd0, es_to_ms_valid}, 32'd0);
        check_eq("rst_allow", {31'd0, es_allow_in}, 32'd1);
        check_eq("rst_pc", es_pc, PC_RST);
        check_eq("rst_alu", es_alu_result, 32'd0);
        check_eq("rst_en", {31'd0, data_sram_en}, 32'd0);
        check_eq("rst_we", {28'd0, data_sram_we}, 32'd0);
        check_eq("rst_rf_we", {28'd0, es_rf_we}, 32'd0);
        check_eq("rst_addr", data_sram_addr, 32'd0);
        check_eq("rst_wdata", data_sram_wdata, 32'd0);
        check_eq("rst_stall", {31'd0, es_load_use_stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU sweep, one op per cycle, src1 = ffff_fff0
        sw_op[0]  = OP_ADD;  sw_s2[0]  = 32'h20;       sw_exp[0]  = 32'h0000_0010;
        sw_op[1]  = OP_SUB;  sw_s2[1]  = 32'h20;       sw_exp[1]  = 32'hffff_ffd0;
        sw_op[2]  = OP_SLT;  sw_s2[2]  = 32'h20;       sw_exp[2]  = 32'h0000_0001;
        sw_op[3]  = OP_SLTU; sw_s2[3]  = 32'h20;       sw_exp[3]  = 32'h0000_0000;
        sw_op[4]  = OP_AND;  sw_s2[4]  = 32'h20;       sw_exp[4]  = 32'h0000_0020;
        sw_op[5]  = OP_NOR;  sw_s2[5]  = 32'h20;       sw_exp[5]  = 32'h0000_000f;
        sw_op[6]  = OP_OR;   sw_s2[6]  = 32'h20;       sw_exp[6]  = 32'hffff_fff0;
        sw_op[7]  = OP_XOR;  sw_s2[7]  = 32'h20;       sw_exp[7]  = 32'hffff_ffd0;
        sw_op[8]  = OP_SLL;  sw_s2[8]  = 32'h20;       sw_exp[8]  = 32'hffff_fff0;
        sw_op[9]  = OP_SRL;  sw_s2[9]  = 32'h4;        sw_exp[9]  = 32'h0fff_ffff;
        sw_op[10] = OP_SRA;  sw_s2[10] = 32'h4;        sw_exp[10] = 32'hffff_ffff;
        sw_op[11] = OP_LUI;  sw_s2[11] = 32'h1234_5000; sw_exp[11] = 32'h1234_5000;
        for (int i = 0; i < 12; i++) begin
            send(32'h1c00_0000 + 32'(i * 4), 32'hffff_fff0, sw_s2[i], sw_op[i],
                 1'b0, 4'h0, 32'h0, 4'hf, 5'd1, sw_exp[i]);
        end
        drain();

        // Store issue
        send(32'h1c00_0100, 32'h1c00_0000, 32'h8, OP_ADD, 1'b0, 4'hf,
             32'hdead_beef, 4'h0, 5'd0, 32'h1c00_0008);
        drain();

        // Back-pressure: same store held three cycles while decode offers another
        ms_allow_in = 1'b0;
        send(32'h1c00_0200, 32'h1c00_0000, 32'h8, OP_ADD, 1'b0, 4'hf,
             32'hdead_beef, 4'h0, 5'd0, 32'h1c00_0008);
        for (int i = 0; i < 3; i++) begin
            ds_to_es_valid = 1'b1;
            ds_pc = 32'h0bad_0000;
            ds_alu_src1 = 32'h1;
            ds_mem_we = 4'h3;
            ds_st_data = 32'h1111_2222;
            @(negedge clk);
            check_eq("bp_allow", {31'd0, es_allow_in}, 32'd0);
            check_eq("bp_pc", es_pc, 32'h1c00_0200);
            check_eq("bp_addr", data_sram_addr, 32'h1c00_0008);
            check_eq("bp_wdata", data_sram_wdata, 32'hdead_beef);
            @(posedge clk);
            #1;
        end
        ds_to_es_valid = 1'b0;
        ds_mem_we = 4'h0;
        drain();

        // Load-use stall
        ms_allow_in = 1'b0;
        send(32'h1c00_0300, 32'h1c00_0000, 32'h10, OP_ADD, 1'b1, 4'h0,
             32'h0, 4'hf, 5'd5, 32'h1c00_0010);
        ds_rf_raddr2 = 5'd5;
        #1;
        check_eq("lu_src2", {31'd0, es_load_use_stall}, 32'd1);
        ds_rf_raddr2 = 5'd31;
        ds_rf_raddr1 = 5'd5;
        #1;
        check_eq("lu_src1", {31'd0, es_load_use_stall}, 32'd1);
        ds_rf_raddr1 = 5'd30;
        #1;
        check_eq("lu_nomatch", {31'd0, es_load_use_stall}, 32'd0);
        drain();
        ds_rf_raddr2 = 5'd5;
        #1;
        check_eq("empty_stall", {31'd0, es_load_use_stall}, 32'd0);
        check_eq("empty_rf_we", {28'd0, es_rf_we}, 32'd0);
        check_eq("empty_en", {31'd0, data_sram_en}, 32'd0);

        ms_allow_in = 1'b0;
        ds_rf_raddr1 = 5'd0;
        ds_rf_raddr2 = 5'd0;
        send(32'h1c00_0400, 32'h1c00_0000, 32'h20, OP_ADD, 1'b1, 4'h0,
             32'h0, 4'hf, 5'd0, 32'h1c00_0020);
        check_eq("lu_r0", {31'd0, es_load_use_stall}, 32'd0);
        drain();

        ms_allow_in = 1'b0;
        ds_rf_raddr2 = 5'd5;
        send(32'h1c00_0500, 32'h3, 32'h4, OP_ADD, 1'b0, 4'h0,
             32'h0, 4'hf, 5'd5, 32'h7);
        check_eq("lu_add", {31'd0, es_load_use_stall}, 32'd0);
        check_eq("hold_rf_we", {28'd0, es_rf_we}, 32'hf);
        drain();
        ds_rf_raddr1 = 5'd30;
        ds_rf_raddr2 = 5'd31;

        // Pipeline flow: four adds back-to-back
        for (int i = 0; i < 4; i++) begin
            send(32'h1c00_0600 + 32'(i * 4), 32'(i * 100), 32'h5, OP_ADD, 1'b0, 4'h0,
                 32'h0, 4'hf, 5'(i + 6), 32'(i * 100 + 5));
            check_eq("flow_valid", {31'd0, es_to_ms_valid}, 32'd1);
            check_eq("flow_allow", {31'd0, es_allow_in}, 32'd1);
        end
        drain();

        // Async reset while a load is valid and requesting
        ms_allow_in = 1'b0;
        send(32'h1c00_0700, 32'h1c00_0000, 32'h40, OP_ADD, 1'b1, 4'h0,
             32'h0, 4'hf, 5'd9, 32'h1c00_0040);
        ms_allow_in = 1'b1;
        #1;
        check_eq("ar_pre_en", {31'd0, data_sram_en}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("ar_valid", {31'd0, es_to_ms_valid}, 32'd0);
        check_eq("ar_en", {31'd0, data_sram_en}, 32'd0);
        check_eq("ar_rf_we", {28'd0, es_rf_we}, 32'd0);
        check_eq("ar_pc", es_pc, PC_RST);
        check_eq("ar_allow", {31'd0, es_allow_in}, 32'd1);
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
        check_eq("req_count", 32'(req_count), 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
